// File: rtl/ct_mmu_jtlb_pkg.sv
// Shared JTLB tag-array definitions: default geometry, FSM encodings, field offsets.
package ct_mmu_jtlb_pkg;

    localparam int unsigned DefWays  = 4;
    localparam int unsigned DefTagW  = 48;
    localparam int unsigned DefFifoW = 4;
    localparam int unsigned DefIdxW  = 8;

    localparam logic StIdle = 1'b0;
    localparam logic StInit = 1'b1;

    // Way i occupies [i*tag_w +: tag_w]; the FIFO field sits directly above the last way.
    function automatic int unsigned way_lsb(input int unsigned way, input int unsigned tag_w);
        return way * tag_w;
    endfunction

    function automatic int unsigned fifo_lsb(input int unsigned ways, input int unsigned tag_w);
        return ways * tag_w;
    endfunction

endpackage

// File: rtl/ct_mmu_jtlb_tag_array_pn_if.sv
// Request/response bundle between JTLB control (master) and the tag array (slave).
interface ct_mmu_jtlb_tag_array_pn_if #(
    parameter int unsigned WAYS   = ct_mmu_jtlb_pkg::DefWays,
    parameter int unsigned TAG_W  = ct_mmu_jtlb_pkg::DefTagW,
    parameter int unsigned FIFO_W = ct_mmu_jtlb_pkg::DefFifoW,
    parameter int unsigned IDX_W  = ct_mmu_jtlb_pkg::DefIdxW
);
    localparam int unsigned DATA_W = WAYS * TAG_W + FIFO_W;

    logic              flush_req;
    logic              req_vld;
    logic              req_ready;
    logic [WAYS:0]     req_wen;
    logic [IDX_W-1:0]  req_idx;
    logic [DATA_W-1:0] req_din;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_dout;
    logic              init_busy;
    logic              init_done;
    logic [WAYS-1:0]   par_err;

    modport master (
        output flush_req, req_vld, req_wen, req_idx, req_din,
        input  req_ready, rd_vld, rd_dout, init_busy, init_done, par_err
    );

    modport slave (
        input  flush_req, req_vld, req_wen, req_idx, req_din,
        output req_ready, rd_vld, rd_dout, init_busy, init_done, par_err
    );

endinterface

// File: rtl/ct_mmu_jtlb_tag_sram.sv
// Behavioural single-port SRAM, active-low CEN/GWEN/per-bit WEN; Q changes only on reads.
module ct_mmu_jtlb_tag_sram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 196
) (
    input  logic                     i_clk,
    input  logic                     i_cen,
    input  logic                     i_gwen,
    input  logic [WIDTH-1:0]         i_wen,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_q
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_cen) begin
            if (!i_gwen) begin
                r_mem[i_addr] <= (r_mem[i_addr] & i_wen) | (i_din & ~i_wen);
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate: enable is captured while clk_in is low so clk_out never glitches.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic w_clk_en;
    logic r_en_lat;

    assign w_clk_en = (global_en & (module_en | local_en)) | external_en;

    always_latch begin
        if (!clk_in) begin
            r_en_lat <= w_clk_en | pad_yy_icg_scan_en;
        end
    end

    assign clk_out = clk_in & r_en_lat;

endmodule

// File: rtl/ct_mmu_jtlb_tag_array_pn.sv
// JTLB tag array: N-way tags + replacement FIFO per row, request front end, invalidate sweep.
// Optional per-way even parity is enabled by defining CT_MMU_JTLB_TAG_PARITY_EN.
module ct_mmu_jtlb_tag_array_pn
    import ct_mmu_jtlb_pkg::*;
#(
    parameter int unsigned WAYS   = DefWays,
    parameter int unsigned TAG_W  = DefTagW,
    parameter int unsigned FIFO_W = DefFifoW,
    parameter int unsigned IDX_W  = DefIdxW
) (
    input logic forever_cpuclk,
    input logic cpurst,
    input logic cp0_mmu_icg_en,
    input logic pad_yy_icg_scan_en,
    ct_mmu_jtlb_tag_array_pn_if.slave bus
);

    localparam int unsigned DATA_W   = WAYS * TAG_W + FIFO_W;
    localparam int unsigned FIFO_LSB = fifo_lsb(WAYS, TAG_W);
`ifdef CT_MMU_JTLB_TAG_PARITY_EN
    localparam int unsigned ROW_W = DATA_W + WAYS;
`else
    localparam int unsigned ROW_W = DATA_W;
`endif

    logic             r_state;
    logic [IDX_W-1:0] r_cnt;
    logic             r_init_done;
    logic             r_rd_vld;
    logic             r_q_live;

    logic             w_init;
    logic             w_cnt_last;
    logic             w_req_ready;
    logic             w_acc;
    logic             w_wr;
    logic             w_rd;
    logic             w_sram_clk;
    logic             w_cen;
    logic             w_gwen;
    logic [IDX_W-1:0] w_addr;
    logic [ROW_W-1:0] w_mask;
    logic [ROW_W-1:0] w_wen;
    logic [ROW_W-1:0] w_din;
    logic [ROW_W-1:0] w_q;

    assign w_init      = (r_state == StInit);
    assign w_cnt_last  = &r_cnt;
    assign w_req_ready = (r_state == StIdle) & ~bus.flush_req;
    assign w_acc       = bus.req_vld & w_req_ready;
    assign w_wr        = w_acc & (|bus.req_wen);
    assign w_rd        = w_acc & ~(|bus.req_wen);

    // Counter wraps to 0 naturally on the last row, leaving it ready for the next flush.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_state     <= StInit;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_q_live    <= 1'b0;
        end else begin
            r_rd_vld    <= w_rd;
            r_q_live    <= r_q_live | w_rd;
            r_init_done <= w_init & w_cnt_last & ~bus.flush_req;
            if (bus.flush_req) begin
                r_state <= StInit;
                r_cnt   <= '0;
            end else if (w_init) begin
                r_cnt <= r_cnt + IDX_W'(1);
                if (w_cnt_last) begin
                    r_state <= StIdle;
                end
            end
        end
    end

    always_comb begin
        w_mask = '0;
        w_din  = '0;
        w_din[DATA_W-1:0] = bus.req_din;
        for (int i = 0; i < WAYS; i++) begin
            w_mask[way_lsb(i, TAG_W) +: TAG_W] = {TAG_W{bus.req_wen[i]}};
        end
        w_mask[FIFO_LSB +: FIFO_W] = {FIFO_W{bus.req_wen[WAYS]}};
`ifdef CT_MMU_JTLB_TAG_PARITY_EN
        // Parity bits ride with their way's enable, so FIFO-only writes leave them alone.
        for (int i = 0; i < WAYS; i++) begin
            w_mask[DATA_W + i] = bus.req_wen[i];
            w_din[DATA_W + i]  = ^bus.req_din[way_lsb(i, TAG_W) +: TAG_W];
        end
`endif
        if (w_init) begin
            w_cen  = 1'b0;
            w_gwen = 1'b0;
            w_wen  = '0;
            w_addr = r_cnt;
            w_din  = '0;
        end else begin
            w_cen  = ~w_acc;
            w_gwen = ~w_wr;
            w_wen  = ~w_mask;
            w_addr = bus.req_idx;
        end
    end

    gated_clk_cell u_icg (
        .clk_in             (forever_cpuclk),
        .global_en          (1'b1),
        .module_en          (cp0_mmu_icg_en),
        .local_en           (w_acc | w_init),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (w_sram_clk)
    );

    ct_mmu_jtlb_tag_sram #(
        .DEPTH (2 ** IDX_W),
        .WIDTH (ROW_W)
    ) u_sram (
        .i_clk  (w_sram_clk),
        .i_cen  (w_cen),
        .i_gwen (w_gwen),
        .i_wen  (w_wen),
        .i_addr (w_addr),
        .i_din  (w_din),
        .o_q    (w_q)
    );

    // The macro has no reset, so its Q is masked until the first read lands.
    assign bus.rd_dout   = r_q_live ? w_q[DATA_W-1:0] : '0;
    assign bus.rd_vld    = r_rd_vld;
    assign bus.req_ready = w_req_ready;
    assign bus.init_busy = w_init;
    assign bus.init_done = r_init_done;

`ifdef CT_MMU_JTLB_TAG_PARITY_EN
    logic [WAYS-1:0] w_par_err;
    always_comb begin
        w_par_err = '0;
        for (int i = 0; i < WAYS; i++) begin
            w_par_err[i] = r_rd_vld & ((^w_q[way_lsb(i, TAG_W) +: TAG_W]) ^ w_q[DATA_W + i]);
        end
    end
    assign bus.par_err = w_par_err;
`else
    assign bus.par_err = '0;
`endif

endmodule
